// File: rtl/servstolic_pkg.sv
// Shared constants and types for the servstolic q-vector logger.
package servstolic_pkg;

  // Width of the saturating lost-event counter.
  localparam int DROP_W = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = '1;

  // FIFO operation for a cycle, encoded as {write accepted, read accepted}.
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Record layout: timestamp sits above the q snapshot.
  function automatic int rec_ts_lsb(input int nq);
    return nq;
  endfunction

  function automatic int rec_ts_msb(input int nq, input int ts_w);
    return nq + ts_w - 1;
  endfunction

endpackage

// File: rtl/servstolic_sync_fifo.sv
// Show-ahead synchronous FIFO: rd_data always reflects the head entry while
// not empty. A write while full is accepted only when a read retires the head
// on the same edge. Occupancy is kept as an explicit counter.
module servstolic_sync_fifo
  import servstolic_pkg::*;
#(
  parameter int width = 48,
  parameter int depth = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     wr_en,
  input  logic [width-1:0]         wr_data,
  output logic                     full,
  input  logic                     rd_en,
  output logic [width-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(depth):0]   level
);

  localparam int AW = $clog2(depth);
  localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(depth);

  logic [width-1:0] mem [depth];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;
  logic [AW:0]      level_next;
  logic             wr_ok;
  logic             rd_ok;
  fifo_op_e         op;

  assign empty   = (level_reg == '0);
  assign full    = (level_reg == LEVEL_FULL);
  assign level   = level_reg;
  assign rd_data = mem[rd_ptr_reg];

  // Reads on an empty FIFO are ignored; a full FIFO takes a write only
  // when the head leaves on the same edge.
  assign rd_ok = rd_en & ~empty;
  assign wr_ok = wr_en & (~full | rd_ok);

  // Occupancy update from the accepted operations of this cycle.
  always_comb begin
    op         = fifo_op_e'({wr_ok, rd_ok});
    level_next = level_reg;
    case (op)
      OP_PUSH: level_next = level_reg + 1'b1;
      OP_POP:  level_next = level_reg - 1'b1;
      default: level_next = level_reg;
    endcase
  end

  // Pointer and occupancy registers; reset discards all contents.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_next;
    end
  end

  // Storage array; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr_reg] <= wr_data;
  end

endmodule

// File: rtl/servstolic_q_logger.sv
// Watches the servstolic core status vector, timestamps every change with a
// free-running cycle counter and streams {ts, q} records through a FIFO.
// Events arriving while the FIFO is full (and not draining) are counted.
module servstolic_q_logger
  import servstolic_pkg::*;
#(
  parameter int nq    = 16,
  parameter int ts_w  = 32,
  parameter int depth = 16
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic [nq-1:0]           q,
  input  logic                    en,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [ts_w+nq-1:0]      m_data,
  output logic [$clog2(depth):0]  level,
  output logic [DROP_W-1:0]       drop_cnt
);

  localparam int TS_LSB = rec_ts_lsb(nq);
  localparam int TS_MSB = rec_ts_msb(nq, ts_w);
  localparam int REC_W  = ts_w + nq;

  logic [ts_w-1:0]   ts_reg;
  logic [ts_w-1:0]   ts_next;
  logic [nq-1:0]     q_prev_reg;
  logic [DROP_W-1:0] drop_reg;
  logic [DROP_W-1:0] drop_next;
  logic              chg;
  logic              push_req;
  logic              drop_ev;
  logic              fifo_full;
  logic              fifo_empty;
  logic [REC_W-1:0]  rec;

  // A change is any difference against the previous sample; the very first
  // comparison after reset is against zero.
  assign chg      = (q != q_prev_reg);
  assign push_req = chg & en;

  // When full, only a same-edge pop (m_valid is guaranteed high) makes room.
  assign drop_ev  = push_req & fifo_full & ~m_ready;

  // Record assembly: timestamp of the cycle q was first seen different.
  always_comb begin
    rec                = '0;
    rec[TS_MSB:TS_LSB] = ts_reg;
    rec[TS_LSB-1:0]    = q;
  end

  // Next-state for the counters; ts wraps silently, drop count saturates.
  always_comb begin
    ts_next   = ts_reg + 1'b1;
    drop_next = drop_reg;
    if (drop_ev && (drop_reg != DROP_MAX)) drop_next = drop_reg + 1'b1;
  end

  // Timestamp, previous-q and drop counter registers. q_prev follows q
  // regardless of en or full so re-enabling never fires a stale event.
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      ts_reg     <= '0;
      q_prev_reg <= '0;
      drop_reg   <= '0;
    end else begin
      ts_reg     <= ts_next;
      q_prev_reg <= q;
      drop_reg   <= drop_next;
    end
  end

  servstolic_sync_fifo #(
    .width (REC_W),
    .depth (depth)
  ) u_fifo (
    .clk     (wb_clk),
    .srst    (wb_rst),
    .wr_en   (push_req),
    .wr_data (rec),
    .full    (fifo_full),
    .rd_en   (m_ready),
    .rd_data (m_data),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign m_valid  = ~fifo_empty;
  assign drop_cnt = drop_reg;

endmodule

// File: tb/tb_servstolic_q_logger.sv
// Bench for servstolic_q_logger (nq=16, ts_w=32, depth=4): directed table,
// hand-written wrap/reset sequences, then randomized traffic against a
// queue-based reference model.
module tb_servstolic_q_logger;

  localparam int NQ    = 16;
  localparam int TS_W  = 32;
  localparam int DEPTH = 4;

  logic            wb_clk;
  logic            wb_rst;
  logic [NQ-1:0]   q;
  logic            en;
  logic            m_valid;
  logic            m_ready;
  logic [TS_W+NQ-1:0] m_data;
  logic [2:0]      level;
  logic [15:0]     drop_cnt;

  int checks;
  int failures;

  servstolic_q_logger #(
    .nq    (NQ),
    .ts_w  (TS_W),
    .depth (DEPTH)
  ) dut (
    .wb_clk   (wb_clk),
    .wb_rst   (wb_rst),
    .q        (q),
    .en       (en),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .level    (level),
    .drop_cnt (drop_cnt)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic        rst;
    logic [15:0] q;
    logic        en;
    logic        rdy;
    logic        ev;
    int          el;
    int          ed;
    logic [47:0] edata;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [15:0] qq, input logic e, input logic rd,
                     input logic ev, input int el, input int ed, input logic [47:0] edata);
    vec_t v;
    v.rst = r; v.q = qq; v.en = e; v.rdy = rd;
    v.ev = ev; v.el = el; v.ed = ed; v.edata = edata;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 60)
        $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Apply inputs on the falling edge, let the rising edge act, sample 1ns later.
  task automatic cyc(input logic r, input logic [15:0] qq, input logic e, input logic rd);
    @(negedge wb_clk);
    wb_rst = r; q = qq; en = e; m_ready = rd;
    @(posedge wb_clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ev, input int el, input int ed,
                            input logic [47:0] edata, input logic chk_data);
    check({tag, "_valid"}, 64'(m_valid), 64'(ev));
    check({tag, "_level"}, 64'(level), 64'(el));
    check({tag, "_drop"}, 64'(drop_cnt), 64'(ed));
    if (ev && chk_data) check({tag, "_data"}, 64'(m_data), 64'(edata));
  endtask

  // Reference model state
  logic [47:0] mq[$];
  logic [31:0] mts;
  logic [15:0] mprev;
  int          mdrop;

  initial begin
    checks = 0; failures = 0;
    wb_rst = 1'b1; q = '0; en = 1'b1; m_ready = 1'b0;

    // ---------------- directed table ----------------
    add(1, 16'h0000, 1, 0, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) add(0, 16'h0000, 1, 0, 0, 0, 0, '0);   // ts 0..4
    add(0, 16'h0001, 1, 0, 1, 1, 0, {32'd5, 16'h0001});                 // ts 5
    add(0, 16'h0001, 1, 1, 0, 0, 0, '0);                                // ts 6 pop
    add(0, 16'h0000, 0, 0, 0, 0, 0, '0);                                // ts 7 masked
    add(0, 16'h0000, 1, 0, 0, 0, 0, '0);                                // ts 8
    add(0, 16'h0000, 1, 0, 0, 0, 0, '0);                                // ts 9
    add(0, 16'h0001, 1, 0, 1, 1, 0, {32'd10, 16'h0001});                // ts 10
    add(0, 16'h0002, 1, 0, 1, 2, 0, {32'd10, 16'h0001});
    add(0, 16'h0003, 1, 0, 1, 3, 0, {32'd10, 16'h0001});
    add(0, 16'h0004, 1, 0, 1, 4, 0, {32'd10, 16'h0001});
    add(0, 16'h0005, 1, 0, 1, 4, 1, {32'd10, 16'h0001});                // ts 14 dropped
    add(0, 16'h0005, 1, 1, 1, 3, 1, {32'd11, 16'h0002});
    add(0, 16'h0005, 1, 1, 1, 2, 1, {32'd12, 16'h0003});
    add(0, 16'h0005, 1, 1, 1, 1, 1, {32'd13, 16'h0004});
    add(0, 16'h0005, 1, 1, 0, 0, 1, '0);                                // ts 18
    add(0, 16'h0006, 1, 0, 1, 1, 1, {32'd19, 16'h0006});
    add(0, 16'h0007, 1, 0, 1, 2, 1, {32'd19, 16'h0006});
    add(0, 16'h0008, 1, 0, 1, 3, 1, {32'd19, 16'h0006});
    add(0, 16'h0009, 1, 0, 1, 4, 1, {32'd19, 16'h0006});                // ts 22 full
    add(0, 16'h000A, 1, 1, 1, 4, 1, {32'd20, 16'h0007});                // ts 23 pop+push
    add(0, 16'h000A, 1, 1, 1, 3, 1, {32'd21, 16'h0008});
    add(0, 16'h000A, 1, 1, 1, 2, 1, {32'd22, 16'h0009});
    add(0, 16'h000A, 1, 1, 1, 1, 1, {32'd23, 16'h000A});                // newest at tail
    add(0, 16'h000A, 1, 1, 0, 0, 1, '0);                                // ts 27
    add(0, 16'h00FF, 0, 0, 0, 0, 1, '0);                                // ts 28 en=0
    add(0, 16'hFF00, 0, 0, 0, 0, 1, '0);
    add(0, 16'hFF00, 1, 0, 0, 0, 1, '0);                                // re-enable, stable
    add(0, 16'hFF01, 1, 0, 1, 1, 1, {32'd31, 16'hFF01});
    add(0, 16'hFF01, 1, 1, 0, 0, 1, '0);                                // ts 32

    foreach (vecs[i]) begin
      cyc(vecs[i].rst, vecs[i].q, vecs[i].en, vecs[i].rdy);
      $display("vec %0d: rst=%0b q=%h en=%0b rdy=%0b -> valid=%0b level=%0d drop=%0d data=%h",
               i, vecs[i].rst, vecs[i].q, vecs[i].en, vecs[i].rdy, m_valid, level, drop_cnt, m_data);
      expect_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].el, vecs[i].ed, vecs[i].edata, 1'b1);
    end

    // ---------------- timestamp wrap ----------------
    force dut.ts_reg = 32'hFFFF_FFFE;
    #1;
    release dut.ts_reg;
    cyc(0, 16'h1234, 1, 0); expect_out("wrap0", 1, 1, 1, {32'hFFFF_FFFE, 16'h1234}, 1);
    cyc(0, 16'h1235, 1, 0); expect_out("wrap1", 1, 2, 1, {32'hFFFF_FFFE, 16'h1234}, 1);
    cyc(0, 16'h1236, 1, 0); expect_out("wrap2", 1, 3, 1, {32'hFFFF_FFFE, 16'h1234}, 1);
    cyc(0, 16'h1236, 1, 1); expect_out("wrap3", 1, 2, 1, {32'hFFFF_FFFF, 16'h1235}, 1);
    cyc(0, 16'h1236, 1, 1); expect_out("wrap4", 1, 1, 1, {32'h0000_0000, 16'h1236}, 1);
    cyc(0, 16'h1236, 1, 1); expect_out("wrap5", 0, 0, 1, '0, 0);
    $display("wrap sequence done: level=%0d drop=%0d", level, drop_cnt);

    // ---------------- reset mid-operation ----------------
    cyc(0, 16'h0001, 1, 0);
    cyc(0, 16'h0002, 1, 0);
    cyc(0, 16'h0003, 1, 0);
    cyc(0, 16'h0004, 1, 0); expect_out("rfill", 1, 4, 1, '0, 0);
    cyc(0, 16'h0005, 1, 0); expect_out("rdrop", 1, 4, 2, '0, 0);
    cyc(0, 16'h0005, 1, 1); expect_out("rpre", 1, 3, 2, '0, 0);
    cyc(1, 16'h0040, 1, 1); expect_out("rst", 0, 0, 0, '0, 0);
    cyc(0, 16'h0040, 1, 0); expect_out("rpost", 1, 1, 0, {32'd0, 16'h0040}, 1);
    cyc(0, 16'h0040, 1, 1); expect_out("rdrain", 0, 0, 0, '0, 0);
    $display("reset sequence done: level=%0d drop=%0d", level, drop_cnt);

    // ---------------- randomized traffic vs. model ----------------
    cyc(1, 16'h0000, 1, 0);
    mq.delete(); mts = '0; mprev = '0; mdrop = 0;
    expect_out("rnd_reset", 0, 0, 0, '0, 0);
    for (int i = 0; i < 4000; i++) begin
      logic        r, e, rd, popped;
      logic [15:0] qq;
      logic [47:0] head;
      int          rd_pct;
      rd_pct = ((i / 500) % 2 == 1) ? 80 : 20;
      r  = ($urandom_range(0, 299) == 0);
      e  = ($urandom_range(0, 9) != 0);
      rd = ($urandom_range(0, 99) < rd_pct);
      qq = q;
      if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 1) == 0) qq = q ^ (16'h1 << $urandom_range(0, 15));
        else                           qq = 16'($urandom);
      end

      // reference: what this edge should do
      popped = 1'b0;
      head   = '0;
      if (r) begin
        mq.delete(); mts = '0; mprev = '0; mdrop = 0;
      end else begin
        if (rd && mq.size() > 0) begin
          head = mq.pop_front();
          popped = 1'b1;
        end
        if (qq != mprev && e) begin
          if (mq.size() < DEPTH) mq.push_back({mts, qq});
          else if (mdrop < 65535) mdrop++;
        end
        mprev = qq;
        mts   = mts + 1;
      end

      cyc(r, qq, e, rd);
      if (popped) $display("rnd %0d: drained ts=%0d q=%h", i, head[47:16], head[15:0]);
      expect_out($sformatf("rnd%0d", i), mq.size() != 0, mq.size(), mdrop,
                 (mq.size() != 0) ? mq[0] : 48'h0, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
